// File: rtl/bf16_add_sched.sv
// Two-requester issue scheduler for the shared FP32/BF16 adder.
// Packs concurrent BF16 ops into one dual-lane issue and returns tagged results.
package bf16_add_sched_pkg;
    typedef enum logic {
        FP32 = 1'b0,
        FP16 = 1'b1
    } fp_fmt_e;
endpackage

module bf16_add_sched
    import bf16_add_sched_pkg::*;
#(
    parameter int LAT       = 1,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  fp_fmt_e          req0_fmt,
    input  logic [31:0]      req0_x,
    input  logic [31:0]      req0_y,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  fp_fmt_e          req1_fmt,
    input  logic [31:0]      req1_x,
    input  logic [31:0]      req1_y,
    input  logic [TAG_W-1:0] req1_tag,
    output fp_fmt_e          dp_fmt,
    output logic [31:0]      dp_x,
    output logic [31:0]      dp_y,
    input  logic [31:0]      dp_r,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [31:0]      rsp0_data,
    output logic [TAG_W-1:0] rsp0_tag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [31:0]      rsp1_data,
    output logic [TAG_W-1:0] rsp1_tag,
    output logic             idle
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int AW = $clog2(RSP_DEPTH);

    logic             r_rr;
    logic [CW-1:0]    r_occ  [2];
    logic [CW-1:0]    r_infl [2];
    logic [AW-1:0]    r_wp   [2];
    logic [AW-1:0]    r_rp   [2];
    logic [31:0]      r_mem_d [2][RSP_DEPTH];
    logic [TAG_W-1:0] r_mem_t [2][RSP_DEPTH];

    logic             r_v    [LAT];
    logic [1:0]       r_mask [LAT];
    fp_fmt_e          r_tfmt [LAT];
    logic [TAG_W-1:0] r_tag0 [LAT];
    logic [TAG_W-1:0] r_tag1 [LAT];

    logic [1:0]       w_valid;
    logic [1:0]       w_elig;
    logic [1:0]       w_grant;
    logic             w_both;
    logic             w_pack;
    logic             w_fp16;
    logic [1:0]       w_push;
    logic [1:0]       w_pop;
    logic [1:0]       w_rsp_rdy;
    logic [31:0]      w_pdata [2];
    logic [TAG_W-1:0] w_ptag  [2];

    assign w_valid   = {req1_valid, req0_valid};
    assign w_rsp_rdy = {rsp1_ready, rsp0_ready};

    // Credit: a requester may issue only if its FIFO has room for every op in flight
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < 2; i++) begin
            w_elig[i] = w_valid[i] &&
                (({1'b0, r_occ[i]} + {1'b0, r_infl[i]}) < (CW + 1)'(RSP_DEPTH));
        end
    end

    // Grant: pack two BF16 ops, else round-robin on conflict, else the lone requester
    always_comb begin
        w_both  = &w_elig;
        w_pack  = w_both && (req0_fmt == FP16) && (req1_fmt == FP16);
        w_grant = w_elig;
        if (w_pack) begin
            w_grant = 2'b11;
        end else if (w_both) begin
            w_grant = r_rr ? 2'b10 : 2'b01;
        end
        w_fp16 = (w_grant[0] && (req0_fmt == FP16)) ||
                 (w_grant[1] && (req1_fmt == FP16));
    end

    assign req0_ready = w_grant[0];
    assign req1_ready = w_grant[1];

    // Operand steering: requester 0 owns the hi BF16 lane, requester 1 the lo lane
    always_comb begin
        dp_fmt = FP32;
        dp_x   = '0;
        dp_y   = '0;
        if (w_fp16) begin
            dp_fmt = FP16;
            dp_x   = {w_grant[0] ? req0_x[15:0] : 16'h0000,
                      w_grant[1] ? req1_x[15:0] : 16'h0000};
            dp_y   = {w_grant[0] ? req0_y[15:0] : 16'h0000,
                      w_grant[1] ? req1_y[15:0] : 16'h0000};
        end else if (w_grant[0]) begin
            dp_x = req0_x;
            dp_y = req0_y;
        end else if (w_grant[1]) begin
            dp_x = req1_x;
            dp_y = req1_y;
        end
    end

    // Round-robin pointer flips only when a conflict was resolved by arbitration
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr <= 1'b0;
        end else if (w_both && !w_pack) begin
            r_rr <= ~r_rr;
        end
    end

    // Tracking valids follow the datapath; reset drops whatever is in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < LAT; s++) begin
                r_v[s] <= 1'b0;
            end
        end else begin
            r_v[0] <= |w_grant;
            for (int s = 1; s < LAT; s++) begin
                r_v[s] <= r_v[s-1];
            end
        end
    end

    // Tracking payload needs no reset; it is qualified by the valid bits
    always_ff @(posedge clk) begin
        r_mask[0] <= w_grant;
        r_tfmt[0] <= w_fp16 ? FP16 : FP32;
        r_tag0[0] <= req0_tag;
        r_tag1[0] <= req1_tag;
        for (int s = 1; s < LAT; s++) begin
            r_mask[s] <= r_mask[s-1];
            r_tfmt[s] <= r_tfmt[s-1];
            r_tag0[s] <= r_tag0[s-1];
            r_tag1[s] <= r_tag1[s-1];
        end
    end

    // Retire: split the adder result into per-requester pushes
    always_comb begin
        w_push     = r_v[LAT-1] ? r_mask[LAT-1] : 2'b00;
        w_pdata[0] = dp_r;
        w_pdata[1] = dp_r;
        if (r_tfmt[LAT-1] == FP16) begin
            w_pdata[0] = {16'h0000, dp_r[31:16]};
            w_pdata[1] = {16'h0000, dp_r[15:0]};
        end
        w_ptag[0] = r_tag0[LAT-1];
        w_ptag[1] = r_tag1[LAT-1];
        for (int i = 0; i < 2; i++) begin
            w_pop[i] = (r_occ[i] != '0) && w_rsp_rdy[i];
        end
    end

    // Occupancy, in-flight counts and FIFO pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_occ[i]  <= '0;
                r_infl[i] <= '0;
                r_wp[i]   <= '0;
                r_rp[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                r_occ[i]  <= r_occ[i] + CW'(w_push[i]) - CW'(w_pop[i]);
                r_infl[i] <= r_infl[i] + CW'(w_grant[i]) - CW'(w_push[i]);
                if (w_push[i]) begin
                    r_wp[i] <= r_wp[i] + AW'(1);
                end
                if (w_pop[i]) begin
                    r_rp[i] <= r_rp[i] + AW'(1);
                end
            end
        end
    end

    // FIFO storage writes
    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (w_push[i]) begin
                r_mem_d[i][r_wp[i]] <= w_pdata[i];
                r_mem_t[i][r_wp[i]] <= w_ptag[i];
            end
        end
    end

    // Credit accounting should make a push into a full FIFO impossible
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                assert (!(w_push[i] && (r_occ[i] == CW'(RSP_DEPTH))));
            end
        end
    end

    assign rsp0_valid = (r_occ[0] != '0);
    assign rsp0_data  = r_mem_d[0][r_rp[0]];
    assign rsp0_tag   = r_mem_t[0][r_rp[0]];
    assign rsp1_valid = (r_occ[1] != '0);
    assign rsp1_data  = r_mem_d[1][r_rp[1]];
    assign rsp1_tag   = r_mem_t[1][r_rp[1]];

    assign idle = (r_infl[0] == '0) && (r_infl[1] == '0) &&
                  (r_occ[0] == '0) && (r_occ[1] == '0);

endmodule

// File: tb/tb_bf16_add_sched.sv
// Bench for bf16_add_sched: behavioural adder stub plus per-requester
// scoreboard of expected {tag, result} computed from operand values.
module tb_bf16_add_sched;
    import bf16_add_sched_pkg::*;

    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int TW    = 4;

    logic          clk;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic          req0_ready, req1_ready;
    fp_fmt_e       req0_fmt, req1_fmt;
    logic [31:0]   req0_x, req0_y, req1_x, req1_y;
    logic [TW-1:0] req0_tag, req1_tag;
    fp_fmt_e       dp_fmt;
    logic [31:0]   dp_x, dp_y, dp_r;
    logic          rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0]   rsp0_data, rsp1_data;
    logic [TW-1:0] rsp0_tag, rsp1_tag;
    logic          idle;

    int n_tests = 0;
    int n_fail  = 0;

    logic [35:0] exp0[$], exp1[$], act0[$], act1[$];

    logic [15:0] vals [6] = '{16'h3F00, 16'h3F80, 16'h3FC0,
                              16'h4000, 16'h4040, 16'h3E80};

    bf16_add_sched #(.LAT(LAT), .RSP_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_fmt(req0_fmt), .req0_x(req0_x), .req0_y(req0_y),
        .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_fmt(req1_fmt), .req1_x(req1_x), .req1_y(req1_y),
        .req1_tag(req1_tag),
        .dp_fmt(dp_fmt), .dp_x(dp_x), .dp_y(dp_y), .dp_r(dp_r),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_data(rsp0_data), .rsp0_tag(rsp0_tag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_data(rsp1_data), .rsp1_tag(rsp1_tag),
        .idle(idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] b);
        real r;
        int  e;
        if (b[30:0] == 31'h0) return 0.0;
        e = int'(b[30:23]);
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        while (e > 127) begin r = r * 2.0; e--; end
        while (e < 127) begin r = r / 2.0; e++; end
        return r;
    endfunction

    function automatic logic [31:0] r2f(input real v);
        real r;
        int  e;
        int  m;
        logic [31:0] o;
        if (v == 0.0) return 32'h0;
        r = v;
        e = 127;
        while (r >= 2.0) begin r = r / 2.0; e++; end
        while (r < 1.0) begin r = r * 2.0; e--; end
        m = int'((r - 1.0) * 8388608.0);
        o = {1'b0, e[7:0], m[22:0]};
        return o;
    endfunction

    function automatic logic [31:0] add32(input logic [31:0] a, b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [15:0] add16(input logic [15:0] a, b);
        logic [31:0] t;
        t = add32({a, 16'h0}, {b, 16'h0});
        return t[31:16];
    endfunction

    // Expected response for one request, from the operand values alone
    function automatic logic [31:0] ref_rsp(input fp_fmt_e f,
                                            input logic [31:0] x, y);
        if (f == FP32) return add32(x, y);
        return {16'h0, add16(x[15:0], y[15:0])};
    endfunction

    // Adder stub: fixed LAT-cycle delay, lane-wise BF16 or FP32 sum
    fp_fmt_e     d_fmt [LAT];
    logic [31:0] d_x [LAT];
    logic [31:0] d_y [LAT];

    initial begin
        for (int s = 0; s < LAT; s++) begin
            d_fmt[s] = FP32; d_x[s] = 0; d_y[s] = 0;
        end
    end

    always @(posedge clk) begin
        d_fmt[0] <= dp_fmt; d_x[0] <= dp_x; d_y[0] <= dp_y;
        for (int s = 1; s < LAT; s++) begin
            d_fmt[s] <= d_fmt[s-1]; d_x[s] <= d_x[s-1]; d_y[s] <= d_y[s-1];
        end
    end

    always_comb begin
        dp_r = 32'h0;
        if (d_fmt[LAT-1] == FP32)
            dp_r = add32(d_x[LAT-1], d_y[LAT-1]);
        else
            dp_r = {add16(d_x[LAT-1][31:16], d_y[LAT-1][31:16]),
                    add16(d_x[LAT-1][15:0], d_y[LAT-1][15:0])};
    end

    // Monitor: record accepted requests as expectations, pops as actuals
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready)
                exp0.push_back({req0_tag, ref_rsp(req0_fmt, req0_x, req0_y)});
            if (req1_valid && req1_ready)
                exp1.push_back({req1_tag, ref_rsp(req1_fmt, req1_x, req1_y)});
            if (rsp0_valid && rsp0_ready) act0.push_back({rsp0_tag, rsp0_data});
            if (rsp1_valid && rsp1_ready) act1.push_back({rsp1_tag, rsp1_data});
        end
    end

    task automatic gen(output fp_fmt_e f, output logic [31:0] x, y);
        f = ($urandom_range(0, 1) == 1) ? FP16 : FP32;
        if (f == FP32) begin
            x = {vals[$urandom_range(0, 5)], 16'h0};
            y = {vals[$urandom_range(0, 5)], 16'h0};
        end else begin
            x = {16'($urandom), vals[$urandom_range(0, 5)]};
            y = {16'($urandom), vals[$urandom_range(0, 5)]};
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp0.delete(); exp1.delete(); act0.delete(); act1.delete();
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (idle) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        req0_fmt = FP32; req1_fmt = FP32;
        req0_x = 0; req0_y = 0; req1_x = 0; req1_y = 0;
        req0_tag = 0; req1_tag = 0;
        do_reset();
        @(negedge clk);
        n_tests++;
        if (idle !== 1'b1) begin
            n_fail++; $display("FAIL reset_idle: got %b want 1", idle);
        end
        n_tests++;
        if ({rsp1_valid, rsp0_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_rsp_valid: got %b want 00", {rsp1_valid, rsp0_valid});
        end
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 00", {req1_ready, req0_ready});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_pack();
        bit ok;
        do_reset();
        req0_fmt = FP16; req0_x = 32'hABCD3F80; req0_y = 32'h00004000;
        req0_tag = 4'd1;
        req1_fmt = FP16; req1_x = 32'h12343FC0; req1_y = 32'h00003FC0;
        req1_tag = 4'd2;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL pack_ready: got %b want 11", {req1_ready, req0_ready});
        end
        n_tests++;
        if (dp_fmt !== FP16) begin
            n_fail++; $display("FAIL pack_fmt: got %0d want FP16", dp_fmt);
        end
        n_tests++;
        if (dp_x !== 32'h3F803FC0) begin
            n_fail++; $display("FAIL pack_dp_x: got %h want 3f803fc0", dp_x);
        end
        n_tests++;
        if (dp_y !== 32'h40003FC0) begin
            n_fail++; $display("FAIL pack_dp_y: got %h want 40003fc0", dp_y);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL pack_drain: idle never rose"); end
        n_tests++;
        if (act0.size() != 1 || act0[0] !== {4'd1, 32'h00004040}) begin
            n_fail++;
            $display("FAIL pack_rsp0: got %0d entries head %h want 1 entry 100004040",
                     act0.size(), act0.size() ? act0[0] : 36'h0);
        end
        n_tests++;
        if (act1.size() != 1 || act1[0] !== {4'd2, 32'h00004040}) begin
            n_fail++;
            $display("FAIL pack_rsp1: got %0d entries head %h want 1 entry 200004040",
                     act1.size(), act1.size() ? act1[0] : 36'h0);
        end
    endtask

    task automatic test_fp32_conflict();
        bit ok;
        logic [1:0] g;
        logic exp_g;
        do_reset();
        req0_fmt = FP32; req0_x = 32'h3F800000; req0_y = 32'h40000000;
        req1_fmt = FP32; req1_x = 32'h3F800000; req1_y = 32'h40000000;
        req0_tag = 4'($urandom); req1_tag = 4'($urandom);
        req0_valid = 1'b1; req1_valid = 1'b1;
        exp_g = 1'b0;
        g = 2'b00;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            g = {req1_ready, req0_ready};
            n_tests++;
            if (g !== (exp_g ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_grant cycle %0d: got %b want %b", c, g,
                         exp_g ? 2'b10 : 2'b01);
            end
            exp_g = ~exp_g;
            @(posedge clk); #1;
            if (g[0]) req0_tag = 4'($urandom);
            if (g[1]) req1_tag = 4'($urandom);
        end
        if (g[1]) req1_valid = 1'b0;
        else      req0_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain(ok);
        n_tests++;
        if (!ok || act0.size() != exp0.size() || act1.size() != exp1.size()
            || act0.size() != 5 || act1.size() != 4) begin
            n_fail++;
            $display("FAIL rr_counts: got %0d/%0d want 5/4 (model %0d/%0d)",
                     act0.size(), act1.size(), exp0.size(), exp1.size());
        end
        for (int i = 0; i < act0.size() && i < exp0.size(); i++) begin
            n_tests++;
            if (act0[i] !== exp0[i] || act0[i][31:0] !== 32'h40400000) begin
                n_fail++;
                $display("FAIL rr_rsp0[%0d]: got %h want %h", i, act0[i], exp0[i]);
            end
        end
        for (int i = 0; i < act1.size() && i < exp1.size(); i++) begin
            n_tests++;
            if (act1[i] !== exp1[i] || act1[i][31:0] !== 32'h40400000) begin
                n_fail++;
                $display("FAIL rr_rsp1[%0d]: got %h want %h", i, act1[i], exp1[i]);
            end
        end
    endtask

    task automatic test_mixed();
        bit ok;
        logic [31:0] x1;
        do_reset();
        req0_fmt = FP32; req0_x = 32'h3F800000; req0_y = 32'h40000000;
        req1_fmt = FP32; req1_x = 32'h3FC00000; req1_y = 32'h3F000000;
        req0_tag = 4'd3; req1_tag = 4'd4;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL mixed_first: got %b want 01", {req1_ready, req0_ready});
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        x1 = {16'hBEEF, vals[$urandom_range(0, 5)]};
        req1_fmt = FP16; req1_x = x1; req1_y = {16'h0, vals[1]}; req1_tag = 4'd5;
        req0_fmt = FP32; req0_x = {vals[$urandom_range(0, 5)], 16'h0};
        req0_tag = 4'd6; req0_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL mixed_grant1: got %b want 10", {req1_ready, req0_ready});
        end
        n_tests++;
        if (dp_fmt !== FP16 || dp_x !== {16'h0, x1[15:0]}) begin
            n_fail++;
            $display("FAIL mixed_lane: got fmt %0d x %h want 1 %h",
                     dp_fmt, dp_x, {16'h0, x1[15:0]});
        end
        @(posedge clk); #1;
        req1_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({req1_ready, req0_ready} !== 2'b01 || dp_fmt !== FP32 ||
            dp_x !== req0_x) begin
            n_fail++;
            $display("FAIL mixed_grant0: got rdy %b fmt %0d x %h want 01 0 %h",
                     {req1_ready, req0_ready}, dp_fmt, dp_x, req0_x);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drain(ok);
        n_tests++;
        if (!ok || act0.size() != 2 || act1.size() != 2 ||
            exp0.size() != 2 || exp1.size() != 2) begin
            n_fail++;
            $display("FAIL mixed_counts: got %0d/%0d want 2/2", act0.size(), act1.size());
        end
        for (int i = 0; i < act0.size() && i < exp0.size(); i++) begin
            n_tests++;
            if (act0[i] !== exp0[i]) begin
                n_fail++;
                $display("FAIL mixed_rsp0[%0d]: got %h want %h", i, act0[i], exp0[i]);
            end
        end
        for (int i = 0; i < act1.size() && i < exp1.size(); i++) begin
            n_tests++;
            if (act1[i] !== exp1[i]) begin
                n_fail++;
                $display("FAIL mixed_rsp1[%0d]: got %h want %h", i, act1[i], exp1[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int acc;
        fp_fmt_e f;
        logic [31:0] x, y;
        do_reset();
        rsp0_ready = 1'b0;
        gen(f, x, y);
        req0_fmt = FP16; req0_x = x; req0_y = y; req0_tag = 4'($urandom);
        req0_valid = 1'b1;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (req0_ready) acc++;
            @(posedge clk); #1;
        end
        n_tests++;
        if (acc != DEPTH) begin
            n_fail++; $display("FAIL bp_accepts: got %0d want %0d", acc, DEPTH);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        n_tests++;
        if (rsp0_valid !== 1'b1 || req0_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_pop_cycle: got valid %b ready %b want 1 0",
                     rsp0_valid, req0_ready);
        end
        @(posedge clk); #1;
        rsp0_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_credit_back: got %b want 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drain(ok);
        n_tests++;
        if (!ok || act0.size() != DEPTH + 1 || exp0.size() != DEPTH + 1) begin
            n_fail++;
            $display("FAIL bp_counts: got %0d want %0d", act0.size(), DEPTH + 1);
        end
        for (int i = 0; i < act0.size() && i < exp0.size(); i++) begin
            n_tests++;
            if (act0[i] !== exp0[i]) begin
                n_fail++;
                $display("FAIL bp_rsp0[%0d]: got %h want %h", i, act0[i], exp0[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        bit seen;
        fp_fmt_e f;
        logic [31:0] x, y;
        do_reset();
        gen(f, x, y);
        req0_fmt = f; req0_x = x; req0_y = y; req0_tag = 4'd7;
        req0_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL rmid_issue: got %b want 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp0.delete(); exp1.delete(); act0.delete(); act1.delete();
        @(negedge clk);
        n_tests++;
        if (idle !== 1'b1) begin
            n_fail++; $display("FAIL rmid_idle: got %b want 1", idle);
        end
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            if (rsp0_valid || rsp1_valid) seen = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (seen) begin
            n_fail++; $display("FAIL rmid_ghost: got rsp_valid 1 want 0");
        end
        @(posedge clk); #1;
        gen(f, x, y);
        req0_fmt = f; req0_x = x; req0_y = y; req0_tag = 4'd9;
        req0_valid = 1'b1;
        @(negedge clk);
        n_tests++;
        if (req0_ready !== 1'b1) begin
            n_fail++; $display("FAIL rmid_next: got %b want 1", req0_ready);
        end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        drain(ok);
        n_tests++;
        if (!ok || act0.size() != 1 || exp0.size() != 1 || act0[0] !== exp0[0]) begin
            n_fail++;
            $display("FAIL rmid_rsp: got %0d entries head %h want 1 entry %h",
                     act0.size(), act0.size() ? act0[0] : 36'h0,
                     exp0.size() ? exp0[0] : 36'h0);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit acc0, acc1;
        fp_fmt_e f;
        logic [31:0] x, y;
        int c;
        do_reset();
        acc0 = 1'b0; acc1 = 1'b0;
        c = 0;
        while (c < 600) begin
            if (!req0_valid || acc0) begin
                req0_valid = 1'b0;
                if (c < 400 && $urandom_range(0, 3) != 0) begin
                    gen(f, x, y);
                    req0_fmt = f; req0_x = x; req0_y = y;
                    req0_tag = 4'($urandom); req0_valid = 1'b1;
                end
            end
            if (!req1_valid || acc1) begin
                req1_valid = 1'b0;
                if (c < 400 && $urandom_range(0, 3) != 0) begin
                    gen(f, x, y);
                    req1_fmt = f; req1_x = x; req1_y = y;
                    req1_tag = 4'($urandom); req1_valid = 1'b1;
                end
            end
            if (c >= 400 && !req0_valid && !req1_valid) break;
            rsp0_ready = ($urandom_range(0, 3) != 0);
            rsp1_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            c++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain(ok);
        n_tests++;
        if (!ok || act0.size() != exp0.size() || act1.size() != exp1.size()) begin
            n_fail++;
            $display("FAIL b2b_counts: got %0d/%0d want %0d/%0d",
                     act0.size(), act1.size(), exp0.size(), exp1.size());
        end
        for (int i = 0; i < act0.size() && i < exp0.size(); i++) begin
            n_tests++;
            if (act0[i] !== exp0[i]) begin
                n_fail++;
                $display("FAIL b2b_rsp0[%0d]: got %h want %h", i, act0[i], exp0[i]);
            end
        end
        for (int i = 0; i < act1.size() && i < exp1.size(); i++) begin
            n_tests++;
            if (act1[i] !== exp1[i]) begin
                n_fail++;
                $display("FAIL b2b_rsp1[%0d]: got %h want %h", i, act1[i], exp1[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        test_reset();
        test_pack();
        test_fp32_conflict();
        test_mixed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bf16_add_sched.md
Name: bf16_add_sched

Overview:
- Two-requester issue scheduler for the shared multi-precision adder `bf16_add`.
- Accepts independent FP32 or BF16 add requests from two ports.
- Packs concurrent BF16 requests into one FP16-mode issue, using both lanes; otherwise arbitrates round-robin.
- Tracks operations in flight through the fixed-latency datapath and returns each result, with its tag, through a per-requester response FIFO with backpressure.

Parameters:
- LAT, 1: datapath latency in cycles from `dp_x`/`dp_y`/`dp_fmt` to `dp_r`; must be ≥1.
- RSP_DEPTH, 4: entries per response FIFO; power of two, ≥2.
- TAG_W, 4: width of the requester tag.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  op accepted this cycle when high with valid
- req0_fmt  in  fp_fmt_e  FP32 or FP16 (BF16)
- req0_x, req0_y  in  32  operands; BF16 operands in [15:0], [31:16] ignored
- req0_tag  in  TAG_W  returned with result
- req1_valid, req1_ready, req1_fmt, req1_x, req1_y, req1_tag: same as requester 0
- dp_fmt  out  fp_fmt_e  format to adder
- dp_x, dp_y  out  32  operands to adder
- dp_r  in  32  adder result, LAT cycles after issue
- rsp0_valid  out  1  result available
- rsp0_ready  in  1  consumer pops
- rsp0_data  out  32  FP32 result, or BF16 result zero-extended in [15:0]
- rsp0_tag  out  TAG_W  tag of the result
- rsp1_valid, rsp1_ready, rsp1_data, rsp1_tag: same as response port 0
- idle  out  1  nothing in flight and both FIFOs empty

Behaviour:
- Credit:
  - `elig_i = req_i_valid && (occ_i + infl_i < RSP_DEPTH)`.
  - `occ_i` and `infl_i` are registered counters.
  - A pop in cycle t frees credit from cycle t+1 only.
- Grant, decided combinationally each cycle:
  - Both eligible and both FP16: PACK. Both readies go high; `rr` is unchanged.
  - Both eligible and at least one FP32: grant `req[rr]` only; `rr` becomes the other requester next cycle.
  - One eligible: grant it; `rr` is unchanged.
  - None eligible: no issue.
- Ready:
  - `req_i_ready = grant_i`.
  - Ready may depend on valid.
  - Valid must stay stable until accepted; the bench checks this.
- Issue operand mapping:
  - FP32 grant: `dp_fmt=FP32`; `dp_x`/`dp_y` = requester operands.
  - Any FP16 issue: `dp_fmt=FP16`. Requester 0 always uses the hi lane (`dp_x[31:16] = req0_x[15:0]`); requester 1 always uses the lo lane (`dp_x[15:0] = req1_x[15:0]`). The same mapping applies to `dp_y`.
  - An unused lane is driven with 16'h0000.
  - No issue: `dp_x = dp_y = 0` and `dp_fmt = FP32`.
  - All `dp_*` outputs are combinational from the grant.
- Tracking pipeline:
  - LAT-stage shift register of {v, mask[1:0], fmt, tag0, tag1}.
  - Stage 0 is loaded on issue; `v=0` otherwise.
  - Issue increments `infl_i` for each granted i.
- Retire, when the stage LAT-1 entry has `v=1` in the same cycle `dp_r` is valid:
  - For each i with `mask[i]`: push to FIFO i, decrement `infl_i`, increment `occ_i`.
  - FIFO 0 data: FP32 gives `dp_r`; FP16 gives `{16'h0, dp_r[31:16]}`.
  - FIFO 1 data: FP32 gives `dp_r`; FP16 gives `{16'h0, dp_r[15:0]}`.
- Response FIFO:
  - Standard FIFO; `rsp_valid = occ_i != 0`; data and tag come from the head entry.
  - Pop on `valid && ready`.
  - Push and pop in the same cycle leave `occ` unchanged.
  - Overflow cannot occur by credit; an assertion flags push while full.
- Counters:
  - `occ` and `infl` range 0..RSP_DEPTH.
  - Simultaneous issue and retire for the same i leave `infl_i` unchanged.
- `idle = (infl0 | infl1 | occ0 | occ1) == 0`, registered-count based.
- Ordering: results return in issue order per requester; there is no ordering guarantee across requesters.
- Reset, synchronous:
  - Clears all pipeline valids, counters, FIFO pointers and `rr`.
  - Outputs after reset: `rsp*_valid = 0`, `req*_ready` follows the grant logic, `idle = 1`.
  - In-flight operations are discarded; results arriving after reset are ignored.

Test Plan:
- PACK: req0 FP16 x=0x3F80, y=0x4000 (1.0+2.0), tag 1; req1 FP16 x=0x3FC0, y=0x3FC0 (1.5+1.5), tag 2; same cycle.
  - Both readies high at issue, with `dp_fmt=FP16`, `dp_x=0x3F803FC0`, `dp_y=0x40003FC0`.
  - LAT cycles later: `rsp0_data=0x00004040` with tag 1, and `rsp1_data=0x00004040` with tag 2.
- FP32 conflict: both request FP32 1.0+2.0 (0x3F800000+0x40000000) continuously, rr=0 after reset.
  - Grants alternate 0,1,0,1.
  - Every response is 0x40400000.
- Mixed: req0 FP32 with req1 FP16 at rr=1.
  - req1 issues alone in the lo lane (`dp_x[31:16]=0`); next cycle req0 issues FP32.
  - No PACK occurs.
- Backpressure: `rsp0_ready=0` with req0 streaming FP16 alone.
  - Exactly RSP_DEPTH=4 accepts, then `req0_ready` stays low.
  - Raise `rsp0_ready` for one pop; `req0_ready` rises the following cycle, not the same cycle.
- Reset mid-operation: assert `rst` one cycle after issue with LAT=2.
  - No `rsp_valid` ever appears for the discarded op.
  - `idle=1` the cycle after reset.
  - The next request is accepted normally.
